// File: rtl/pc_gen_if.sv
// pc_gen_if -- bundle of fetch-side signals around the PC generator.
//   slave modport  : the PC generator (consumes redirects/RAS requests,
//                    drives pc and status pulses).
//   master modport : the surrounding pipeline / testbench.
// Handshake: pc is fetched on a cycle where fetch_valid && fetch_ready are
// both high; fetch_valid never depends on fetch_ready, and a redirect or
// RAS pop drops the current pc without requiring fetch_ready.
// ras_count is a debug view of the return-address-stack occupancy.
interface pc_gen_if #(
  parameter int XLEN         = 32,
  parameter int NUM_REDIRECT = 2,
  parameter int RAS_DEPTH    = 4
);
  localparam int CW = $clog2(RAS_DEPTH + 1);

  logic [NUM_REDIRECT-1:0]      redirect_en;
  logic [NUM_REDIRECT*XLEN-1:0] redirect_vect;
  logic                         ras_push;
  logic [XLEN-1:0]              ras_push_addr;
  logic                         ras_pop;
  logic                         fetch_ready;
  logic                         fetch_valid;
  logic [XLEN-1:0]              pc;
  logic [NUM_REDIRECT-1:0]      redirect_ack;
  logic                         ras_empty;
  logic                         ras_full;
  logic                         misalign_err;
  logic                         ras_underflow;
  logic [CW-1:0]                ras_count;

  modport slave (
    input  redirect_en, redirect_vect, ras_push, ras_push_addr, ras_pop,
           fetch_ready,
    output fetch_valid, pc, redirect_ack, ras_empty, ras_full,
           misalign_err, ras_underflow, ras_count
  );

  modport master (
    output redirect_en, redirect_vect, ras_push, ras_push_addr, ras_pop,
           fetch_ready,
    input  fetch_valid, pc, redirect_ack, ras_empty, ras_full,
           misalign_err, ras_underflow, ras_count
  );
endinterface

// File: rtl/pc_gen.sv
// pc_gen -- fetch program-counter generator with prioritised redirects and
// a circular return-address stack (RAS).
// Ports:
//   clk    : single clock, all state on posedge
//   reset  : asynchronous active-high reset
//   bus    : pc_gen_if.slave (redirects, RAS push/pop, fetch handshake,
//            pc, redirect_ack, ras_empty/full, misalign_err,
//            ras_underflow, ras_count debug)
// Next-pc priority: lowest-index redirect, then RAS pop (non-empty),
// then pc+4 on an accepted fetch, otherwise hold.
module pc_gen #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              NUM_REDIRECT = 2,
  parameter int              RAS_DEPTH    = 4
) (
  input logic     clk,
  input logic     reset,
  pc_gen_if.slave bus
);
  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CW = $clog2(RAS_DEPTH + 1);

  logic [XLEN-1:0]         pc_q, pc_d;
  logic                    valid_q;
  logic [NUM_REDIRECT-1:0] ack_q, ack_d;
  logic                    mis_q, mis_d;
  logic                    unf_q, unf_d;
  logic [PW-1:0]           top_q, top_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [XLEN-1:0]         ras_mem [RAS_DEPTH];

  logic                    redir_any;
  logic                    empty, full;
  logic                    pop_ok;
  logic                    load;
  logic [XLEN-1:0]         raw;
  logic                    mem_we;
  logic [PW-1:0]           mem_waddr;

  always_comb begin
    redir_any = |bus.redirect_en;
    empty     = (cnt_q == '0);
    full      = (cnt_q == CW'(RAS_DEPTH));
    pop_ok    = bus.ras_pop && !redir_any && !empty;
    unf_d     = bus.ras_pop && !redir_any && empty;

    // Scan high to low so the lowest asserted channel is the final winner.
    ack_d = '0;
    raw   = '0;
    for (int i = NUM_REDIRECT - 1; i >= 0; i--) begin
      if (bus.redirect_en[i]) begin
        ack_d    = '0;
        ack_d[i] = 1'b1;
        raw      = bus.redirect_vect[i*XLEN +: XLEN];
      end
    end
    if (pop_ok) raw = ras_mem[top_q];

    load  = redir_any || pop_ok;
    mis_d = load && (raw[1:0] != 2'b00);

    pc_d = pc_q;
    if (load)                          pc_d = {raw[XLEN-1:2], 2'b00};
    else if (valid_q && bus.fetch_ready) pc_d = pc_q + XLEN'(4);

    // RAS bookkeeping. Push+pop on a non-empty stack replaces the top in
    // place; a lone push while full wraps onto the oldest slot.
    top_d     = top_q;
    cnt_d     = cnt_q;
    mem_we    = 1'b0;
    mem_waddr = top_q;
    if (bus.ras_push && pop_ok) begin
      mem_we = 1'b1;
    end else if (bus.ras_push) begin
      mem_we    = 1'b1;
      mem_waddr = top_q + PW'(1);
      top_d     = top_q + PW'(1);
      if (!full) cnt_d = cnt_q + CW'(1);
    end else if (pop_ok) begin
      top_d = top_q - PW'(1);
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= RESET_VECTOR;
      valid_q <= 1'b0;
      ack_q   <= '0;
      mis_q   <= 1'b0;
      unf_q   <= 1'b0;
      top_q   <= '0;
      cnt_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      valid_q <= 1'b1;
      ack_q   <= ack_d;
      mis_q   <= mis_d;
      unf_q   <= unf_d;
      top_q   <= top_d;
      cnt_q   <= cnt_d;
    end
  end

  // Entry storage is not reset; occupancy alone defines what is valid.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) ras_mem[mem_waddr] <= bus.ras_push_addr;
  end

  assign bus.pc            = pc_q;
  assign bus.fetch_valid   = valid_q;
  assign bus.redirect_ack  = ack_q;
  assign bus.misalign_err  = mis_q;
  assign bus.ras_underflow = unf_q;
  assign bus.ras_empty     = empty;
  assign bus.ras_full      = full;
  assign bus.ras_count     = cnt_q;
endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;
  localparam int XLEN = 32;
  localparam int NR   = 2;
  localparam int RD   = 4;

  logic clk;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  logic [XLEN-1:0] exp_q[$];

  pc_gen_if #(.XLEN(XLEN), .NUM_REDIRECT(NR), .RAS_DEPTH(RD)) bus ();

  pc_gen #(
    .XLEN(XLEN), .RESET_VECTOR(32'h0000_0000),
    .NUM_REDIRECT(NR), .RAS_DEPTH(RD)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // driver / checker tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic exp_pc(input logic [XLEN-1:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk_pc(input string tag);
    logic [XLEN-1:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s observed=%0h expected=queue_entry", tag, bus.pc);
    end else begin
      e = exp_q.pop_front();
      chk(tag, bus.pc, e);
    end
  endtask

  task automatic drive(input logic [NR-1:0] en, input logic [XLEN-1:0] v0,
                       input logic [XLEN-1:0] v1, input logic push,
                       input logic [XLEN-1:0] paddr, input logic pop,
                       input logic fr);
    bus.redirect_en   = en;
    bus.redirect_vect = {v1, v0};
    bus.ras_push      = push;
    bus.ras_push_addr = paddr;
    bus.ras_pop       = pop;
    bus.fetch_ready   = fr;
  endtask

  initial begin
    reset = 1'b1;
    drive('0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
    #1;
    chk("rst_pc", bus.pc, 32'h0);
    chk("rst_valid", bus.fetch_valid, 1'b0);
    chk("rst_ack", bus.redirect_ack, 2'b00);
    chk("rst_empty", bus.ras_empty, 1'b1);
    chk("rst_full", bus.ras_full, 1'b0);
    chk("rst_mis", bus.misalign_err, 1'b0);
    chk("rst_unf", bus.ras_underflow, 1'b0);
    tick();
    chk("rst_hold_pc", bus.pc, 32'h0);

    // release, sequential fetch
    reset = 1'b0;
    drive('0, '0, '0, 1'b0, '0, 1'b0, 1'b1);
    chk("first_valid", bus.fetch_valid, 1'b0);
    exp_pc(32'h0); tick(); chk_pc("seq0");
    chk("valid_up", bus.fetch_valid, 1'b1);
    exp_pc(32'h4); tick(); chk_pc("seq4");
    exp_pc(32'h8); tick(); chk_pc("seq8");
    exp_pc(32'hC); tick(); chk_pc("seqC");

    // both redirects, channel 0 wins, fetch_ready low
    drive(2'b11, 32'h100, 32'h200, 1'b0, '0, 1'b0, 1'b0);
    exp_pc(32'h100); tick(); chk_pc("redir_prio");
    chk("ack01", bus.redirect_ack, 2'b01);
    chk("mis_aligned", bus.misalign_err, 1'b0);
    drive('0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
    exp_pc(32'h100); tick(); chk_pc("hold_not_ready");
    chk("ack_clear", bus.redirect_ack, 2'b00);

    // misaligned redirect on channel 1
    drive(2'b10, '0, 32'h203, 1'b0, '0, 1'b0, 1'b0);
    exp_pc(32'h200); tick(); chk_pc("misalign_pc");
    chk("ack10", bus.redirect_ack, 2'b10);
    chk("mis_pulse", bus.misalign_err, 1'b1);
    drive('0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
    exp_pc(32'h200); tick(); chk_pc("misalign_hold");
    chk("mis_clear", bus.misalign_err, 1'b0);

    // five pushes into a depth-4 stack
    for (int i = 1; i <= 5; i++) begin
      drive('0, '0, '0, 1'b1, XLEN'(i * 16), 1'b0, 1'b0);
      exp_pc(32'h200); tick(); chk_pc("push_hold");
      if (i == 4) chk("full4", bus.ras_full, 1'b1);
    end
    chk("full_cnt", bus.ras_count, 3'd4);
    chk("full5", bus.ras_full, 1'b1);

    // four good pops then one on empty
    drive('0, '0, '0, 1'b0, '0, 1'b1, 1'b0);
    exp_pc(32'h50); tick(); chk_pc("pop50");
    chk("not_full", bus.ras_full, 1'b0);
    exp_pc(32'h40); tick(); chk_pc("pop40");
    exp_pc(32'h30); tick(); chk_pc("pop30");
    exp_pc(32'h20); tick(); chk_pc("pop20");
    chk("pop_empty", bus.ras_empty, 1'b1);
    chk("no_unf_yet", bus.ras_underflow, 1'b0);
    exp_pc(32'h20); tick(); chk_pc("pop_underflow_hold");
    chk("unf_pulse", bus.ras_underflow, 1'b1);
    chk("unf_empty", bus.ras_empty, 1'b1);
    drive('0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
    exp_pc(32'h20); tick(); chk_pc("after_unf");
    chk("unf_clear", bus.ras_underflow, 1'b0);

    // pop blocked by a redirect leaves the stack alone
    drive('0, '0, '0, 1'b1, 32'h60, 1'b0, 1'b0);
    exp_pc(32'h20); tick(); chk_pc("push60");
    drive(2'b01, 32'h300, '0, 1'b0, '0, 1'b1, 1'b0);
    exp_pc(32'h300); tick(); chk_pc("redir_over_pop");
    chk("redir_pop_nounf", bus.ras_underflow, 1'b0);
    chk("redir_pop_cnt", bus.ras_count, 3'd1);
    drive('0, '0, '0, 1'b0, '0, 1'b1, 1'b0);
    exp_pc(32'h60); tick(); chk_pc("pop60");

    // push+pop on empty stack
    drive('0, '0, '0, 1'b1, 32'h70, 1'b1, 1'b0);
    exp_pc(32'h60); tick(); chk_pc("pushpop_empty_hold");
    chk("pushpop_empty_unf", bus.ras_underflow, 1'b1);
    chk("pushpop_empty_cnt", bus.ras_count, 3'd1);
    drive('0, '0, '0, 1'b0, '0, 1'b1, 1'b0);
    exp_pc(32'h70); tick(); chk_pc("pop70");

    // increment wraps at the top of the address space
    drive(2'b01, 32'hFFFF_FFFC, '0, 1'b0, '0, 1'b0, 1'b1);
    exp_pc(32'hFFFF_FFFC); tick(); chk_pc("to_top");
    drive('0, '0, '0, 1'b0, '0, 1'b0, 1'b1);
    exp_pc(32'h0); tick(); chk_pc("wrap0");
    drive('0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
    exp_pc(32'h0); tick(); chk_pc("wrap_hold");

    // push+pop on non-empty stack replaces top
    drive('0, '0, '0, 1'b1, 32'h80, 1'b0, 1'b0);
    exp_pc(32'h0); tick(); chk_pc("push80");
    drive('0, '0, '0, 1'b1, 32'h90, 1'b1, 1'b0);
    exp_pc(32'h80); tick(); chk_pc("pushpop80");
    chk("pushpop_cnt", bus.ras_count, 3'd1);
    drive('0, '0, '0, 1'b0, '0, 1'b1, 1'b0);
    exp_pc(32'h90); tick(); chk_pc("pop90");
    chk("pop90_empty", bus.ras_empty, 1'b1);

    // asynchronous reset mid-sequence
    drive(2'b01, 32'h444, '0, 1'b1, 32'hA0, 1'b0, 1'b1);
    exp_pc(32'h444); tick(); chk_pc("pre_reset");
    drive('0, '0, '0, 1'b1, 32'hB0, 1'b0, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_pc", bus.pc, 32'h0);
    chk("async_empty", bus.ras_empty, 1'b1);
    chk("async_valid", bus.fetch_valid, 1'b0);
    chk("async_ack", bus.redirect_ack, 2'b00);
    tick();
    chk("reset_held_pc", bus.pc, 32'h0);
    chk("reset_held_cnt", bus.ras_count, 3'd0);
    reset = 1'b0;
    drive('0, '0, '0, 1'b0, '0, 1'b1, 1'b0);
    exp_pc(32'h0); tick(); chk_pc("post_reset_pop");
    chk("post_reset_unf", bus.ras_underflow, 1'b1);

    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter XLEN, default 32, width of PC and all target vectors.
REQ-002 Parameter RESET_VECTOR, default 32'h0000_0000, PC value loaded by reset.
REQ-003 Parameter NUM_REDIRECT, default 2, number of prioritised redirect channels (1..8).
REQ-004 Parameter RAS_DEPTH, default 4, return-address-stack entries (power of 2, 2..16).
REQ-005 clk  input  1  single clock; all state updates on posedge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 redirect_en  input  NUM_REDIRECT  per-channel redirect request; bit 0 highest priority.
REQ-008 redirect_vect  input  NUM_REDIRECT*XLEN  packed targets; channel i occupies bits [i*XLEN +: XLEN].
REQ-009 ras_push  input  1  push ras_push_addr onto return-address stack.
REQ-010 ras_push_addr  input  XLEN  return address to push.
REQ-011 ras_pop  input  1  redirect PC to the stack top and pop it.
REQ-012 fetch_ready  input  1  consumer accepts current pc this cycle.
REQ-013 fetch_valid  output  1  pc holds a valid fetch address.
REQ-014 pc  output  XLEN  current fetch address, registered.
REQ-015 redirect_ack  output  NUM_REDIRECT  registered one-hot: channel whose redirect was taken last cycle.
REQ-016 ras_empty / ras_full  output  1 each  combinational from occupancy count.
REQ-017 misalign_err  output  1  registered one-cycle pulse: last taken target had nonzero bits [1:0].
REQ-018 ras_underflow  output  1  registered one-cycle pulse: pop requested while empty.

Function
REQ-019 Next-PC priority per cycle SHALL be: (1) lowest-index asserted redirect_en, (2) ras_pop with stack non-empty, (3) increment when fetch_valid && fetch_ready, (4) hold.
REQ-020 Redirect and RAS-pop SHALL take effect on the next posedge regardless of fetch_ready; the address in pc is then dropped, not fetched.
REQ-021 Increment SHALL be pc + 4, modulo 2^XLEN (0xFFFF_FFFC wraps to 0x0000_0000, no flag).
REQ-022 Any loaded target SHALL have bits [1:0] forced to 0; misalign_err pulses the following cycle if the raw bits were nonzero.
REQ-023 redirect_ack SHALL be one-hot for the winning channel for one cycle, zero otherwise; losing channels are dropped, not queued.
REQ-024 fetch_valid SHALL be 0 during reset and on the first posedge after deassertion; 1 thereafter until next reset.
REQ-025 RAS SHALL be a circular LIFO of RAS_DEPTH entries with a top pointer and occupancy count 0..RAS_DEPTH.
REQ-026 Push when not full: write entry above top, count+1; push when full: overwrite oldest entry, count stays RAS_DEPTH.
REQ-027 Pop when non-empty and no redirect: load stack top into pc, count-1.
REQ-028 Pop while any redirect_en is asserted SHALL leave the stack unchanged, with no underflow pulse.
REQ-029 Pop while empty SHALL not alter pc or stack; ras_underflow pulses next cycle.
REQ-030 Simultaneous push and pop (stack non-empty, no redirect): pc loads old top; pushed address replaces that top; count unchanged.
REQ-031 Simultaneous push and pop on empty stack: push performed, count becomes 1, no pc change, ras_underflow pulses.
REQ-032 Push SHALL be performed regardless of redirect or fetch handshake.
REQ-033 pc SHALL change only as REQ-019 states; with fetch_valid && !fetch_ready and no redirect/pop, pc holds.

Reset
REQ-034 Asserting reset SHALL immediately force pc=RESET_VECTOR, fetch_valid=0, redirect_ack=0, misalign_err=0, ras_underflow=0, occupancy 0 (ras_empty=1, ras_full=0).
REQ-035 Reset mid-operation SHALL discard pending redirect/pop/push and stack contents; entry storage need not be cleared.
REQ-036 No output SHALL take a non-reset value while reset is high.

Verification
REQ-037 Reset release, fetch_ready=1 -> fetch_valid 0 first cycle, then pc 0x0,0x4,0x8,0xC on successive cycles.
REQ-038 redirect_en=2'b11, vect0=0x100, vect1=0x200, fetch_ready=0 -> pc=0x100, redirect_ack=2'b01 next cycle.
REQ-039 Redirect target 0x203 -> pc=0x200, misalign_err one-cycle pulse.
REQ-040 Push 0x10,0x20,0x30,0x40,0x50 (depth 4), then five pops -> pc 0x50,0x40,0x30,0x20; fifth pop: pc holds, ras_underflow pulses, ras_empty=1.
REQ-041 pc=0xFFFF_FFFC, fetch_ready=1 -> pc=0x0000_0000 next cycle.
REQ-042 Stack holds 0x80, assert push 0x90 + pop same cycle -> pc=0x80, count 1, next pop -> pc=0x90; reset asserted mid-sequence -> pc=0x0 immediately, ras_empty=1.
